// File: rtl/sram_mem_responder_if.sv
// sram_mem_responder_if: MEM-stage load/store handshake between the pipeline and the SRAM responder
interface sram_mem_responder_if;
  logic        rd_en;
  logic        wr_en;
  logic        ready;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  modport master (output rd_en, wr_en, address, write_data, input read_data, ready);
  modport slave  (input rd_en, wr_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_mem_responder.sv
// sram_mem_responder: services 32-bit MEM-stage loads/stores as two half-word async SRAM accesses
module sram_mem_responder #(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_ADDR_W = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_mem_responder_if.slave    mem,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [15:0]            SRAM_DQ,
  output logic                   SRAM_WE_N
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   wr_q, wr_d;
  logic [SRAM_ADDR_W-2:0] word_q, word_d;
  logic [31:0]            wdata_q, wdata_d, rdata_q, rdata_d;
  logic                   req, last, act, drv;
  logic [31:0]            offs;
  assign req           = mem.rd_en | mem.wr_en;
  assign offs          = mem.address - 32'(BASE_ADDR);
  assign last          = cnt_q == CW'(WAIT_CYCLES - 1);
  assign act           = state_q == LO || state_q == HI;
  assign drv           = act & wr_q;
  assign mem.ready     = state_q == IDLE ? ~req : state_q == DONE;
  assign mem.read_data = rdata_q;
  assign SRAM_ADDR     = act ? {word_q, state_q == HI} : '0;
  assign SRAM_WE_N     = ~drv;
  assign SRAM_DQ       = drv ? (state_q == HI ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  // Request inputs are only sampled in IDLE; LO/HI work from the latched copy
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = LO;
        cnt_d   = '0;
        wr_d    = mem.wr_en;
        word_d  = (SRAM_ADDR_W-1)'(offs >> 2);
        wdata_d = mem.write_data;
      end
      LO, HI: begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
        if (last) begin
          state_d = state_q == LO ? HI : DONE;
          if (!wr_q && state_q == LO) rdata_d[15:0] = SRAM_DQ;
          if (!wr_q && state_q == HI) rdata_d[31:16] = SRAM_DQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
